// File: rtl/fifo_mc_pkg.sv
// Shared helpers and types for the multichannel FIFO.
package fifo_mc_pkg;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic underflow;
        logic overflow;
    } fifo_err_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, array left unreset.
module sdp_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_multichannel.sv
// N independent FIFOs in one shared BRAM, each channel owning a 2**LOG2_DEPTH region.
// Optional sticky error reporting is enabled with the FIFO_MC_ERRCHK_EN macro.
module fifo_multichannel
    import fifo_mc_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int LOG2_DEPTH   = 9,
    parameter int NUM_CHANNELS = 4,
    parameter int AF_MARGIN    = 20,
    localparam int CW          = chan_w(NUM_CHANNELS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  we,
    input  logic [CW-1:0]                         wchannel,
    input  logic [WIDTH-1:0]                      wdata,
    input  logic                                  re,
    input  logic [CW-1:0]                         rchannel,
    output logic                                  rvalid,
    output logic [WIDTH-1:0]                      rdata,
    output logic [CW-1:0]                         rdata_channel,
    output logic [NUM_CHANNELS-1:0]               empty,
    output logic [NUM_CHANNELS-1:0]               full,
    output logic [NUM_CHANNELS-1:0]               almostfull,
    output logic [NUM_CHANNELS*(LOG2_DEPTH+1)-1:0] count,
    output logic [1:0]                            error
);

    localparam int D  = 2 ** LOG2_DEPTH;
    localparam int AW = CW + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] AF_TH = (LOG2_DEPTH + 1)'(D - AF_MARGIN);
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(D);
    localparam logic [CW:0] NCH = (CW + 1)'(NUM_CHANNELS);

    logic [CW-1:0]         w_ch, r_ch;
    logic                  w_in_range, r_in_range;
    logic                  wr_ok, rd_ok;
    logic [NUM_CHANNELS-1:0] full_vec, empty_vec;
    logic [LOG2_DEPTH-1:0] wptr_arr [NUM_CHANNELS];
    logic [LOG2_DEPTH-1:0] rptr_arr [NUM_CHANNELS];
    logic                  rvalid_q;
    logic [CW-1:0]         rchan_q;

    // A single channel has no spare index values, so any index maps to channel 0.
    assign w_in_range = (NUM_CHANNELS == 1) || ({1'b0, wchannel} < NCH);
    assign r_in_range = (NUM_CHANNELS == 1) || ({1'b0, rchannel} < NCH);
    assign w_ch       = (NUM_CHANNELS == 1) ? '0 : wchannel;
    assign r_ch       = (NUM_CHANNELS == 1) ? '0 : rchannel;
    assign wr_ok      = we && w_in_range && !full_vec[w_ch];
    assign rd_ok      = re && r_in_range && !empty_vec[r_ch];

    sdp_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (NUM_CHANNELS * D),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i ({w_ch, wptr_arr[w_ch]}),
        .wdata_i (wdata),
        .re_i    (rd_ok),
        .raddr_i ({r_ch, rptr_arr[r_ch]}),
        .rdata_o (rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            logic                  wr_hit, rd_hit;
            logic [LOG2_DEPTH-1:0] wptr_q, rptr_q;
            logic [LOG2_DEPTH:0]   count_q, count_d;
            logic                  empty_q, full_q, af_q;

            assign wr_hit = wr_ok && (w_ch == CW'(gi));
            assign rd_hit = rd_ok && (r_ch == CW'(gi));

            always_comb begin
                count_d = count_q;
                if (wr_hit && !rd_hit) begin
                    count_d = count_q + 1'b1;
                end else if (rd_hit && !wr_hit) begin
                    count_d = count_q - 1'b1;
                end
            end

            // Flags track the next count so they are valid the cycle after an update.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    count_q <= '0;
                    empty_q <= 1'b1;
                    full_q  <= 1'b0;
                    af_q    <= 1'b0;
                end else begin
                    if (wr_hit) wptr_q <= wptr_q + 1'b1;
                    if (rd_hit) rptr_q <= rptr_q + 1'b1;
                    count_q <= count_d;
                    empty_q <= (count_d == '0);
                    full_q  <= (count_d == FULL_CNT);
                    af_q    <= (count_d >= AF_TH);
                end
            end

            assign wptr_arr[gi]   = wptr_q;
            assign rptr_arr[gi]   = rptr_q;
            assign full_vec[gi]   = full_q;
            assign empty_vec[gi]  = empty_q;
            assign almostfull[gi] = af_q;
            assign count[gi*(LOG2_DEPTH+1) +: (LOG2_DEPTH+1)] = count_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
        end
        if (rd_ok) begin
            rchan_q <= r_ch;
        end
    end

    assign rvalid        = rvalid_q;
    assign rdata_channel = rchan_q;
    assign empty         = empty_vec;
    assign full          = full_vec;

`ifdef FIFO_MC_ERRCHK_EN
    fifo_err_t err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (we && !wr_ok) err_q.overflow  <= 1'b1;
            if (re && !rd_ok) err_q.underflow <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_multichannel.sv
// Directed self-checking bench for fifo_multichannel (D=16, 3 channels, AF_MARGIN=4).
module tb_fifo_multichannel;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int N  = 3;
    localparam int AF = 4;
    localparam int CB = L + 1;

    logic          clk;
    logic          reset;
    logic          we;
    logic [1:0]    wchannel;
    logic [W-1:0]  wdata;
    logic          re;
    logic [1:0]    rchannel;
    logic          rvalid;
    logic [W-1:0]  rdata;
    logic [1:0]    rdata_channel;
    logic [N-1:0]  empty;
    logic [N-1:0]  full;
    logic [N-1:0]  almostfull;
    logic [N*CB-1:0] count;
    logic [1:0]    error;

    int n_total = 0;
    int n_bad   = 0;

    fifo_multichannel #(
        .WIDTH        (W),
        .LOG2_DEPTH   (L),
        .NUM_CHANNELS (N),
        .AF_MARGIN    (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .we            (we),
        .wchannel      (wchannel),
        .wdata         (wdata),
        .re            (re),
        .rchannel      (rchannel),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rdata_channel (rdata_channel),
        .empty         (empty),
        .full          (full),
        .almostfull    (almostfull),
        .count         (count),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CB-1:0] cnt(input int c);
        return count[c*CB +: CB];
    endfunction

    // Expected error value depends on whether the error checker is built in.
    function automatic logic [1:0] errx(input logic [1:0] e);
`ifdef FIFO_MC_ERRCHK_EN
        return e;
`else
        return 2'b00 & e;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [W-1:0] d);
        we = 1'b1; re = 1'b0; wchannel = 2'(ch); wdata = d;
        cycle();
        we = 1'b0;
        $display("wr ch%0d data=%0h", ch, d);
    endtask

    task automatic rd(input string tag, input int ch, input logic [W-1:0] exp);
        re = 1'b1; we = 1'b0; rchannel = 2'(ch);
        cycle();
        re = 1'b0;
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp));
        chk({tag, "_rch"}, 64'(rdata_channel), 64'(ch));
        $display("rd ch%0d data=%0h", ch, rdata);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0;
        wchannel = '0; rchannel = '0; wdata = '0;
        repeat (2) cycle();
        chk("rst_empty", 64'(empty), 64'h7);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_af", 64'(almostfull), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_error", 64'(error), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        reset = 1'b0;

        // 1: fill and drain channel 1
        for (int i = 0; i < 16; i++) begin
            wr(1, W'(i));
            chk("t1_cnt", 64'(cnt(1)), 64'(i + 1));
            chk("t1_af", 64'(almostfull[1]), 64'(i + 1 >= 12));
            chk("t1_full", 64'(full[1]), 64'(i == 15));
        end
        chk("t1_empty1", 64'(empty[1]), 64'd0);
        for (int i = 0; i < 16; i++) begin
            rd("t1_rd", 1, W'(i));
            chk("t1_cnt_rd", 64'(cnt(1)), 64'(15 - i));
            chk("t1_af_rd", 64'(almostfull[1]), 64'(15 - i >= 12));
        end
        chk("t1_empty_end", 64'(empty[1]), 64'd1);
        chk("t1_full_end", 64'(full[1]), 64'd0);
        cycle();
        chk("t1_idle_rvalid", 64'(rvalid), 64'd0);

        // 2: simultaneous write and read on an empty channel
        we = 1'b1; re = 1'b1; wchannel = 2'd0; rchannel = 2'd0; wdata = 32'hA5;
        cycle();
        we = 1'b0; re = 1'b0;
        chk("t2_cnt", 64'(cnt(0)), 64'd1);
        chk("t2_rvalid", 64'(rvalid), 64'd0);
        chk("t2_empty0", 64'(empty[0]), 64'd0);
        chk("t2_error", 64'(error), 64'(errx(2'b10)));
        rd("t2_rd", 0, 32'hA5);
        chk("t2_empty_end", 64'(empty[0]), 64'd1);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst2_error", 64'(error), 64'h0);
        chk("rst2_empty", 64'(empty), 64'h7);

        // 3: simultaneous write and read on a full channel
        for (int i = 0; i < 16; i++) wr(2, W'(100 + i));
        chk("t3_full", 64'(full[2]), 64'd1);
        chk("t3_af", 64'(almostfull[2]), 64'd1);
        we = 1'b1; re = 1'b1; wchannel = 2'd2; rchannel = 2'd2; wdata = 32'hDEAD;
        cycle();
        we = 1'b0; re = 1'b0;
        chk("t3_rvalid", 64'(rvalid), 64'd1);
        chk("t3_rdata", 64'(rdata), 64'd100);
        chk("t3_cnt", 64'(cnt(2)), 64'd15);
        chk("t3_full_after", 64'(full[2]), 64'd0);
        chk("t3_error", 64'(error), 64'(errx(2'b01)));
        for (int i = 1; i < 16; i++) rd("t3_rd", 2, W'(100 + i));
        chk("t3_empty_end", 64'(empty[2]), 64'd1);

        // 4: interleaved channels
        for (int i = 0; i < 5; i++)
            for (int c = 0; c < 3; c++) wr(c, W'(c * 256 + i));
        chk("t4_cnt0", 64'(cnt(0)), 64'd5);
        chk("t4_cnt1", 64'(cnt(1)), 64'd5);
        chk("t4_cnt2", 64'(cnt(2)), 64'd5);
        for (int i = 0; i < 5; i++) begin
            rd("t4_rd2", 2, W'(512 + i));
            rd("t4_rd0", 0, W'(i));
            rd("t4_rd1", 1, W'(256 + i));
        end
        chk("t4_empty", 64'(empty), 64'h7);

        // 5: steady-state wrap on channel 1
        for (int k = 0; k < 3; k++) wr(1, W'(1000 + k));
        for (int k = 0; k < 40; k++) begin
            we = 1'b1; re = 1'b1; wchannel = 2'd1; rchannel = 2'd1; wdata = W'(1003 + k);
            cycle();
            chk("t5_rvalid", 64'(rvalid), 64'd1);
            chk("t5_rdata", 64'(rdata), 64'(1000 + k));
            chk("t5_cnt", 64'(cnt(1)), 64'd3);
            $display("wr+rd ch1 wdata=%0h rdata=%0h", 1003 + k, rdata);
        end
        we = 1'b0; re = 1'b0;
        for (int k = 40; k < 43; k++) rd("t5_drain", 1, W'(1000 + k));
        chk("t5_empty", 64'(empty[1]), 64'd1);

        // 6: reset with data stored and a read in flight
        for (int i = 0; i < 7; i++) wr(0, W'(50 + i));
        re = 1'b1; rchannel = 2'd0;
        cycle();
        re = 1'b0;
        chk("t6_pre_rvalid", 64'(rvalid), 64'd1);
        chk("t6_pre_rdata", 64'(rdata), 64'd50);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_rvalid", 64'(rvalid), 64'd0);
        chk("t6_cnt0", 64'(cnt(0)), 64'd0);
        chk("t6_empty", 64'(empty), 64'h7);
        chk("t6_error", 64'(error), 64'h0);
        re = 1'b1; rchannel = 2'd0;
        cycle();
        re = 1'b0;
        chk("t6_rd_rvalid", 64'(rvalid), 64'd0);
        chk("t6_rd_error", 64'(error), 64'(errx(2'b10)));

        // out-of-range channel index
        we = 1'b1; wchannel = 2'd3; wdata = 32'h77;
        cycle();
        we = 1'b0;
        chk("oor_wr_error", 64'(error), 64'(errx(2'b11)));
        chk("oor_wr_count", 64'(count), 64'h0);
        chk("oor_wr_empty", 64'(empty), 64'h7);
        re = 1'b1; rchannel = 2'd3;
        cycle();
        re = 1'b0;
        chk("oor_rd_rvalid", 64'(rvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
